// File: rtl/bpu_pkg.sv
// Shared types for the branch predict unit: branch conditions, 2-bit counter states,
// BTB entry layout and the saturating counter step.
package bpu_pkg;

  localparam int BPU_PC_W  = 9;
  localparam int BPU_IDX_W = 4;
  localparam int BPU_TAG_W = BPU_PC_W - BPU_IDX_W - 2;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    logic [BPU_PC_W-1:0]  target;
  } btb_entry_t;

  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    if (taken) return (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bpu_table.sv
// Direction counters and tagged BTB: one combinational read port for IF, one
// read-modify-write port for EX training. Reads return pre-edge contents (no bypass).
module bpu_table
  import bpu_pkg::*;
#(
  parameter int IDX_W = BPU_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  output btb_entry_t       rd_btb,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  input  logic             wr_force,
  input  btb_entry_t       wr_btb
);
  localparam int ENTRIES = 1 << IDX_W;

  ctr_t       ctr_q [ENTRIES];
  btb_entry_t btb_q [ENTRIES];

  assign rd_ctr = ctr_q[rd_idx];
  assign rd_btb = btb_q[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]       <= WNT;
        btb_q[i].valid <= 1'b0;
      end
    end else if (wr_en) begin
      // jumps are always taken, so they pin the counter instead of stepping it
      ctr_q[wr_idx] <= wr_force ? ST : ctr_next(ctr_q[wr_idx], wr_taken);
      if (wr_taken) btb_q[wr_idx] <= wr_btb;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// IF-stage direction/target prediction and EX-stage resolution for RV32I branches and jumps,
// with redirect generation, table training and a saturating mispredict counter.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W  = BPU_PC_W,
  parameter int IDX_W = BPU_IDX_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic [31:0]      ex_rs2,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  input  logic             halt,
  output logic [31:0]      pc_four,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);
  ctr_t       rd_ctr;
  btb_entry_t rd_btb;
  btb_entry_t wr_btb;

  logic            active, cond, taken, mispredict, upd;
  logic [PC_W-1:0] target, seq_pc, jalr_sum;
  logic            unused_bits;

  bpu_table #(.IDX_W(IDX_W)) u_table (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .rd_btb   (rd_btb),
    .wr_en    (upd),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (taken),
    .wr_force (ex_jal | ex_jalr),
    .wr_btb   (wr_btb)
  );

  assign pred_taken  = ~reset & rd_btb.valid & (rd_btb.tag == if_pc[PC_W-1:IDX_W+2]) & rd_ctr[1];
  assign pred_target = pred_taken ? rd_btb.target : '0;

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      F3_BEQ:  cond = (ex_rs1 == ex_rs2);
      F3_BNE:  cond = (ex_rs1 != ex_rs2);
      F3_BLT:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      F3_BGE:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: cond = (ex_rs1 <  ex_rs2);
      F3_BGEU: cond = (ex_rs1 >= ex_rs2);
      default: cond = 1'b0;
    endcase
  end

  // only the low PC_W bits of any target survive, so add at that width
  assign jalr_sum   = ex_rs1[PC_W-1:0] + ex_imm[PC_W-1:0];
  assign target     = ex_jalr ? {jalr_sum[PC_W-1:1], 1'b0} : ex_pc + ex_imm[PC_W-1:0];
  assign seq_pc     = ex_pc + PC_W'(4);
  assign active     = ex_valid & (ex_branch | ex_jal | ex_jalr);
  assign taken      = active & (ex_jal | ex_jalr | (ex_branch & cond));
  assign mispredict = active & ((taken != ex_pred_taken) | (taken & (target != ex_pred_target)));
  assign upd        = active & ~halt & ~reset;
  assign wr_btb     = '{valid: 1'b1, tag: ex_pc[PC_W-1:IDX_W+2], target: target};
  assign pc_four    = {{(32-PC_W){1'b0}}, ex_pc} + 32'd4;
  assign redirect   = ~reset & (mispredict | halt);
  assign unused_bits = ^{ex_imm[31:PC_W], jalr_sum[0], if_pc[1:0]};

  always_comb begin
    redirect_pc = '0;
    if (!reset) begin
      if (halt)            redirect_pc = ex_pc;
      else if (mispredict) redirect_pc = taken ? target : seq_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                           mispredict_cnt <= '0;
    else if (upd && mispredict && !(&mispredict_cnt))    mispredict_cnt <= mispredict_cnt + 1'b1;
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and randomized checks of branch_predict_unit against a behavioural model
// of the prediction tables and resolution rules.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  if_pc;
  logic        pred_taken;
  logic [8:0]  pred_target;
  logic        ex_valid;
  logic [8:0]  ex_pc;
  logic [31:0] ex_imm, ex_rs1, ex_rs2;
  logic        ex_branch, ex_jal, ex_jalr;
  logic [2:0]  ex_funct3;
  logic        ex_pred_taken;
  logic [8:0]  ex_pred_target;
  logic        halt;
  logic [31:0] pc_four;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic [15:0] mispredict_cnt;

  int total = 0;
  int bad   = 0;

  // model state: counter value 0..3, BTB valid/tag/target, mispredict count
  int m_ctr [16];
  bit m_val [16];
  int m_tag [16];
  int m_tgt [16];
  int m_cnt;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_funct3(ex_funct3),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .halt(halt),
    .pc_four(pc_four), .redirect(redirect), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_ctr[i] = 1; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_pred(input int pc, output bit pt, output int tgt);
    int i;
    i   = (pc >> 2) & 15;
    pt  = m_val[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
    tgt = pt ? m_tgt[i] : 0;
  endtask

  function automatic bit cond_of(input int f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      0: return a == b;
      1: return a != b;
      4: return $signed(a) <  $signed(b);
      5: return $signed(a) >= $signed(b);
      6: return a <  b;
      7: return a >= b;
      default: return 0;
    endcase
  endfunction

  // check all outputs against the model, then advance one clock and update the model
  task automatic cyc();
    bit pt, act, tk, mp, rst, hlt, jump;
    int ptg, tgt, eidx, etag, erpc;
    logic [31:0] sum;
    #1;
    rst = reset;
    hlt = halt;
    model_pred(int'(if_pc), pt, ptg);
    if (rst) begin pt = 0; ptg = 0; end
    check("pred_taken",  pred_taken,  pt);
    check("pred_target", pred_target, ptg);

    jump = ex_jal || ex_jalr;
    act  = ex_valid && (ex_branch || jump);
    tk   = act && (jump || (ex_branch && cond_of(int'(ex_funct3), ex_rs1, ex_rs2)));
    if (ex_jalr) begin
      sum = ex_rs1 + ex_imm;
      tgt = int'(sum & 32'h1FE);
    end else begin
      sum = {23'd0, ex_pc} + ex_imm;
      tgt = int'(sum & 32'h1FF);
    end
    mp = act && ((tk != ex_pred_taken) || (tk && tgt != int'(ex_pred_target)));
    if (rst)      erpc = 0;
    else if (hlt) erpc = int'(ex_pc);
    else if (mp)  erpc = tk ? tgt : ((int'(ex_pc) + 4) & 'h1FF);
    else          erpc = 0;
    check("redirect",       redirect,       !rst && (mp || hlt));
    check("redirect_pc",    redirect_pc,    erpc);
    check("pc_four",        pc_four,        int'(ex_pc) + 4);
    check("mispredict_cnt", mispredict_cnt, m_cnt);

    eidx = (int'(ex_pc) >> 2) & 15;
    etag = int'(ex_pc) >> 6;
    @(posedge clk);
    if (rst) model_reset();
    else if (act && !hlt) begin
      if (jump)    m_ctr[eidx] = 3;
      else if (tk) m_ctr[eidx] = (m_ctr[eidx] == 3) ? 3 : m_ctr[eidx] + 1;
      else         m_ctr[eidx] = (m_ctr[eidx] == 0) ? 0 : m_ctr[eidx] - 1;
      if (tk) begin m_val[eidx] = 1; m_tag[eidx] = etag; m_tgt[eidx] = tgt; end
      if (mp && m_cnt < 65535) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    ex_valid = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_branch = 0; ex_jal = 0; ex_jalr = 0; ex_funct3 = 0;
    ex_pred_taken = 0; ex_pred_target = 0; halt = 0;
  endtask

  task automatic set_br(input int pc, input int f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input bit pt, input int ptg);
    idle();
    ex_valid = 1; ex_branch = 1; ex_pc = 9'(pc); ex_funct3 = 3'(f3);
    ex_rs1 = a; ex_rs2 = b; ex_imm = imm; ex_pred_taken = pt; ex_pred_target = 9'(ptg);
  endtask

  initial begin
    bit pt;
    int ptg, kind;
    model_reset();
    idle();
    reset = 1; if_pc = 9'h010;
    @(negedge clk);
    cyc();
    cyc();
    reset = 0;
    cyc();

    // BEQ taken, predicted not-taken; IF reads the same index in the write cycle
    set_br('h10, 0, 5, 5, 8, 0, 0); if_pc = 9'h010;
    #1;
    check("t2_redirect",    redirect,    1);
    check("t2_redirect_pc", redirect_pc, 'h18);
    check("t2_same_idx",    pred_taken,  0);
    cyc();
    idle(); if_pc = 9'h010;
    #1;
    check("t2_pred_taken",  pred_taken,     1);
    check("t2_pred_target", pred_target,    'h18);
    check("t2_cnt",         mispredict_cnt, 1);
    cyc();

    // BLT -1<1 taken; BLTU same operands not taken while predicted taken
    set_br('h30, 4, 32'hFFFF_FFFF, 1, 'h20, 0, 0); cyc();
    set_br('h30, 6, 32'hFFFF_FFFF, 1, 'h20, 1, 'h50);
    #1;
    check("t3_bltu_rpc", redirect_pc, 'h34);
    cyc();

    // JALR target with bit0 cleared, then a correctly predicted repeat
    idle(); ex_valid = 1; ex_jalr = 1; ex_pc = 9'h040; ex_rs1 = 'h23; ex_imm = 4;
    #1;
    check("t4_rpc",    redirect_pc, 'h26);
    check("t4_pcfour", pc_four,     'h44);
    cyc();
    idle(); if_pc = 9'h040;
    #1;
    check("t4_pred", pred_taken, 1);
    cyc();
    idle(); ex_valid = 1; ex_jalr = 1; ex_pc = 9'h040; ex_rs1 = 'h23; ex_imm = 4;
    ex_pred_taken = 1; ex_pred_target = 9'h026;
    #1;
    check("t4_no_redirect", redirect, 0);
    cyc();

    // halt over a mispredicted BNE: redirect to ex_pc, no training or counting
    set_br('h20, 1, 1, 2, 'h40, 0, 0); halt = 1; if_pc = 9'h020;
    #1;
    check("t5_rpc", redirect_pc, 'h20);
    cyc();
    idle(); if_pc = 9'h020; cyc();
    idle(); halt = 1; ex_pc = 9'h088; cyc();
    set_br('h50, 0, 3, 3, 8, 0, 0); ex_valid = 0; cyc();

    // train to strongly taken, then reset during a training cycle
    for (int k = 0; k < 4; k++) begin
      set_br('h60, 0, 7, 7, 'h10, k > 0, k > 0 ? 'h70 : 0); if_pc = 9'h060; cyc();
    end
    idle(); if_pc = 9'h060;
    #1;
    check("t6_trained", pred_taken, 1);
    cyc();
    set_br('h60, 1, 7, 7, 'h10, 1, 'h70); reset = 1; cyc();
    reset = 0; idle(); if_pc = 9'h060;
    #1;
    check("t6_after_reset", pred_taken, 0);
    cyc();
    set_br('h1FC, 1, 4, 4, 8, 1, 'h004);
    #1;
    check("t6_wrap_rpc", redirect_pc, 0);
    cyc();

    // random traffic, about half the time carrying the model's own prediction
    for (int n = 0; n < 400; n++) begin
      idle();
      ex_pc     = 9'($urandom_range(0, 127) * 4);
      ex_valid  = ($urandom_range(0, 7) != 0);
      kind      = $urandom_range(0, 5);
      ex_jal    = (kind == 1);
      ex_jalr   = (kind == 2);
      ex_branch = (kind >= 4);
      ex_funct3 = 3'($urandom_range(0, 7));
      ex_rs1    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
      ex_rs2    = ($urandom_range(0, 2) == 0) ? ex_rs1 : 32'($urandom_range(0, 511)) - 32'd256;
      ex_imm    = 32'($urandom_range(0, 63)) * 4 - 32'd128;
      if ($urandom_range(0, 1) == 1) begin
        model_pred(int'(ex_pc), pt, ptg);
        ex_pred_taken = pt; ex_pred_target = 9'(ptg);
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1)); ex_pred_target = 9'($urandom_range(0, 511));
      end
      halt  = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 39) == 0);
      if_pc = ($urandom_range(0, 1) == 1) ? ex_pc : 9'($urandom_range(0, 127) * 4);
      cyc();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
